// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and occupancy controller for a FIFO that accepts
// 2-word pushes and 1-word pops. It owns all FIFO state but holds no data.
// It drives the write strobe and the write and read addresses of an external
// storage array.
// Optional feature macro: FIFO_CTRL_ERR_EN. When it is defined, the block
// builds the sticky overflow/underflow flags. When it is undefined, err_ovf
// and err_unf are tied to 0.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_ovf,
  output logic                  err_unf
);

  // full when fewer than two free words remain, i.e. count > D-2
  localparam logic [ADDR_WIDTH:0]   FULL_LIMIT = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 2);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_TWO    = (ADDR_WIDTH+1)'(2);
  // pointer steps; natural ADDR_WIDTH-bit overflow gives the modulo-D wrap
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] W_STEP     = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] R_STEP     = ADDR_WIDTH'(1);

  logic                push_ok;
  logic                pop_ok;
  logic [ADDR_WIDTH:0] count_nxt;

  // Decode flags from registered state, decide acceptance, compute next occupancy
  always_comb begin
    empty     = (count == CNT_ZERO);
    full      = (count > FULL_LIMIT);
    push_ok   = wr & ~full;
    pop_ok    = rd & ~empty;
    w_en      = push_ok;
    count_nxt = count;
    if (push_ok && pop_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (push_ok) begin
      count_nxt = count + CNT_TWO;
    end else if (pop_ok) begin
      count_nxt = count - CNT_ONE;
    end else begin
      count_nxt = count;
    end
  end

  // Advance the pointers and the occupancy on accepted requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr <= PTR_ZERO;
      r_addr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (push_ok) begin
        w_addr <= w_addr + W_STEP;
      end
      if (pop_ok) begin
        r_addr <= r_addr + R_STEP;
      end
      count <= count_nxt;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error flags: set on any rejected push/pop, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr && full) begin
        err_ovf <= 1'b1;
      end
      if (rd && empty) begin
        err_unf <= 1'b1;
      end
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and occupancy controller for the FIFO built around the dual-width register file. It accepts 2-word pushes and 1-word pops, generates `w_addr`, `w_en` and `r_addr` for the storage array, and reports `empty` and `full` to the producer and consumer. Each push writes the upper half of `w_data` to `w_addr` and the lower half to `w_addr+1`, so the upper half is popped first. The block holds no data; it owns all FIFO state.

## Interface
- `ADDR_WIDTH`, default 2: storage address width. Depth D = 2**ADDR_WIDTH words. Must be ≥ 1.
- `clk`  in  1: clock, all state updates on posedge.
- `reset`  in  1: asynchronous, active-high reset.
- `wr`  in  1: push request; one push is 2 words.
- `rd`  in  1: pop request; one pop is 1 word.
- `w_en`  out  1: write strobe to storage, `wr & ~full`.
- `w_addr`  out  ADDR_WIDTH: write pointer; always even.
- `r_addr`  out  ADDR_WIDTH: read pointer; head word address.
- `empty`  out  1: count == 0.
- `full`  out  1: count > D-2, meaning fewer than 2 free words.
- `count`  out  ADDR_WIDTH+1: words currently stored, 0..D.
- `err_ovf`  out  1: sticky, push attempted while full.
- `err_unf`  out  1: sticky, pop attempted while empty.

## Operation
- State registers: `w_addr`, `r_addr`, `count`, `err_ovf`, `err_unf`.
- Push accepted: `wa = wr & ~full`. Pop accepted: `ra = rd & ~empty`.
- Accept decisions use only registered state. There is no pass-through:
  - a pop at count 0 is rejected even if a push happens in the same cycle;
  - a push while full is rejected even if a pop happens in the same cycle.
- On a clock edge with `wa`: `w_addr <= w_addr + 2`, modulo D.
- On a clock edge with `ra`: `r_addr <= r_addr + 1`, modulo D.
- `count <= count + 2*wa - ra`, computed in ADDR_WIDTH+1 bits. The result always stays in 0..D.
- Pointer wrap is natural ADDR_WIDTH-bit overflow. The write pair at D-2 and D-1 never straddles the wrap, because `w_addr` stays even.
- Rejected requests change nothing, except the error flags.
- `w_en` is combinational, so the storage write happens on the same edge that advances `w_addr`.

## Timing
- Reset (asynchronous, immediate) sets:
  - `w_addr=0`, `r_addr=0`, `count=0`
  - `empty=1`, `full=0`, `w_en=0` (with `wr` low)
  - `err_ovf=0`, `err_unf=0`
- Reset asserted mid-operation discards all stored words. The first posedge after reset deasserts behaves as a normal cycle.
- `empty`, `full` and `count` are decoded from registers with no input-to-output path.
- `w_en` has a combinational path from `wr`.
- Latency:
  - a pushed word is readable at `r_addr` the cycle after the push edge;
  - `r_data` changes combinationally in the storage once `r_addr` updates.
- Sustained simultaneous push and pop with room available gives net +1 word per cycle.

## Configuration
- Macro: `FIFO_CTRL_ERR_EN`.
- Defined:
  - `err_ovf` sets on any edge with `wr & full`;
  - `err_unf` sets on any edge with `rd & empty`;
  - both stay set until `reset`.
- Undefined:
  - both ports are still present and tied to 0;
  - no error registers are built;
  - all other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=2, D=4.
1. Assert `reset` mid-run with count=3 → immediately `w_addr=0`, `r_addr=0`, `count=0`, `empty=1`, `full=0`.
2. `wr` for 1 cycle from reset → `w_en=1` during that cycle; next cycle `w_addr=2`, `count=2`, `empty=0`, `full=0`. A second push → `w_addr=0` (wrap), `count=4`, `full=1`.
3. At `count=4`, `wr=1` → `w_en=0`; `w_addr` and `count` unchanged; `err_ovf=1` with the macro, 0 without.
4. From `count=4`, `rd` for 4 cycles → `r_addr` goes 1, 2, 3, 0 and `count` goes 3, 2, 1, 0. `full` drops when `count` reaches 2. `empty=1` at the end.
5. At `count=1`, `wr=1` and `rd=1` together → next cycle `count=2`, `w_addr` advanced by 2, `r_addr` advanced by 1. At `count=3`, the same stimulus → push rejected, `count=2`.
6. At `count=0`, `rd=1` and `wr=1` together → pop rejected, push accepted; next cycle `count=2`, `r_addr` unchanged, `err_unf=1` with the macro.
